// File: rtl/natv_apb_bridge.sv
// natv_apb_bridge
//   Responder-side bridge from the native valid/ready memory bus onto an
//   APB3 segment. One native request at a time is replayed as an APB
//   SETUP/ACCESS pair and completed with a single-cycle mem_ready_o pulse.
//   Slave errors and hung slaves (ACCESS longer than TIMEOUT cycles) still
//   complete the native request. They also set a sticky error flag and
//   record the byte address of the request.
//
// Parameters
//   TIMEOUT   : ACCESS cycles without pready before forced termination (0 = never)
//   ERR_RDATA : read data returned on pslverr / timeout
//
// Ports
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   mem_valid_i/addr_i/wdata_i/wstrb_i : native request (wstrb==0 -> read)
//   mem_rdata_o, mem_ready_o          : native response (ready is a 1-cycle pulse)
//   apb_paddr_o/psel_o/penable_o/pwrite_o/pwdata_o/pstrb_o : APB requester side
//   apb_prdata_i/pready_i/pslverr_i   : APB response
//   err_o, err_addr_o, err_clr_i      : sticky error record and its clear
module natv_apb_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic [31:0] apb_paddr_o,
  output logic        apb_psel_o,
  output logic        apb_penable_o,
  output logic        apb_pwrite_o,
  output logic [31:0] apb_pwdata_o,
  output logic [3:0]  apb_pstrb_o,
  input  logic [31:0] apb_prdata_i,
  input  logic        apb_pready_i,
  input  logic        apb_pslverr_i,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  input  logic        err_clr_i
);

  // Counter is at least 8 bits, wider only when TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         addr_lo_q;   // low address bits, kept for err_addr_o
  logic               mem_ready_q;
  logic [31:0]        mem_rdata_q;
  logic [31:0]        paddr_q;
  logic               psel_q;
  logic               penable_q;
  logic               pwrite_q;
  logic [31:0]        pwdata_q;
  logic [3:0]         pstrb_q;
  logic               err_q;
  logic [31:0]        err_addr_q;

  logic               timeout_hit;
  logic               xfer_done_d;
  logic               xfer_err_d;
  logic [31:0]        rdata_d;
  logic               err_d;

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
    xfer_done_d = (state_q == S_ACCESS) && (apb_pready_i || timeout_hit);
    // pslverr only counts when pready is high; a timeout is an error too.
    xfer_err_d  = (state_q == S_ACCESS) &&
                  ((apb_pready_i && apb_pslverr_i) || (!apb_pready_i && timeout_hit));
    if (pwrite_q)        rdata_d = 32'h0;
    else if (xfer_err_d) rdata_d = ERR_RDATA;
    else                 rdata_d = apb_prdata_i;
    // Setting the error takes priority over a simultaneous clear.
    if (xfer_err_d)      err_d = 1'b1;
    else if (err_clr_i)  err_d = 1'b0;
    else                 err_d = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= 2'b00;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      paddr_q     <= 32'h0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0;
      pstrb_q     <= 4'h0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      err_q <= err_d;
      if (xfer_err_d) err_addr_q <= {paddr_q[31:2], addr_lo_q};
      // Response outputs are pulses; they only go high on the RESP entry edge.
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      case (state_q)
        S_IDLE: begin
          if (mem_valid_i) begin
            paddr_q   <= {mem_addr_i[31:2], 2'b00};
            addr_lo_q <= mem_addr_i[1:0];
            pwrite_q  <= |mem_wstrb_i;
            pwdata_q  <= mem_wdata_i;
            pstrb_q   <= mem_wstrb_i;  // zero for reads by definition
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (xfer_done_d) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= rdata_d;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_ready_o   = mem_ready_q;
  assign mem_rdata_o   = mem_rdata_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;
  assign err_o         = err_q;
  assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_natv_apb_bridge.sv
// Self-checking bench for natv_apb_bridge (TIMEOUT=4).
// Table of single transactions plus hand-written back-to-back and reset cases.
module tb_natv_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  natv_apb_bridge #(.TIMEOUT(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .mem_valid_i(mem_valid), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_wstrb_i(mem_wstrb), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
    .apb_paddr_o(paddr), .apb_psel_o(psel), .apb_penable_o(penable),
    .apb_pwrite_o(pwrite), .apb_pwdata_o(pwdata), .apb_pstrb_o(pstrb),
    .apb_prdata_i(prdata), .apb_pready_i(pready), .apb_pslverr_i(pslverr),
    .err_o(err), .err_addr_o(err_addr), .err_clr_i(err_clr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;      // ACCESS cycles with pready=0 before pready=1
    logic        slverr;
    logic [31:0] prdata;
    logic        clr_hold;   // hold err_clr high during the transaction
    logic [31:0] exp_paddr;
    logic        exp_pwrite;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    int          exp_cyc;    // cycle of mem_ready, valid first high in cycle 0
    logic        exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One native transaction against a behavioural APB slave; all sampling
  // and driving happens on the falling edge.
  task automatic run_txn(input string tag, input vec_t v);
    int   cyc;
    int   acc;
    int   setup_cyc;
    logic seen;
    logic stable;
    logic [31:0] pa;
    logic        pw;
    logic [3:0]  ps;
    seen = 1'b0; stable = 1'b1; acc = 0; setup_cyc = -1;
    pa = 32'h0; pw = 1'b0; ps = 4'h0;
    @(negedge clk);
    err_clr = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".clr"}, {31'h0, err}, 32'h0);
    err_clr   = v.clr_hold;
    mem_valid = 1'b1;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.wstrb;
    cyc = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (psel && !penable && setup_cyc < 0) begin
        setup_cyc = cyc; pa = paddr; pw = pwrite; ps = pstrb;
      end
      if (psel && penable) begin
        acc++;
        if (paddr !== v.exp_paddr || pwdata !== v.wdata ||
            pstrb !== v.exp_pstrb || pwrite !== v.exp_pwrite) stable = 1'b0;
        pready  = (acc > v.waits);
        pslverr = (acc > v.waits) && v.slverr;
        prdata  = v.prdata;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
      if (mem_ready) begin
        seen = 1'b1;
        chk({tag, ".ready_cyc"}, 32'(cyc), 32'(v.exp_cyc));
        chk({tag, ".rdata"}, mem_rdata, v.exp_rdata);
        chk({tag, ".err"}, {31'h0, err}, {31'h0, v.exp_err});
        if (v.exp_err) chk({tag, ".err_addr"}, err_addr, v.exp_eaddr);
        chk({tag, ".psel_in_resp"}, {31'h0, psel | penable}, 32'h0);
        mem_valid = 1'b0;
      end
    end
    chk({tag, ".ready_seen"}, {31'h0, seen}, 32'h1);
    chk({tag, ".setup_cyc"}, 32'(setup_cyc), 32'd1);
    chk({tag, ".paddr"}, pa, v.exp_paddr);
    chk({tag, ".pwrite"}, {31'h0, pw}, {31'h0, v.exp_pwrite});
    chk({tag, ".pstrb"}, {28'h0, ps}, {28'h0, v.exp_pstrb});
    chk({tag, ".access_stable"}, {31'h0, stable}, 32'h1);
    @(negedge clk);
    chk({tag, ".ready_after"}, {31'h0, mem_ready}, 32'h0);
    chk({tag, ".rdata_after"}, mem_rdata, 32'h0);
    err_clr = 1'b0;
    $display("txn %s addr=%h wstrb=%h waits=%0d -> paddr=%h ready_cyc=%0d err=%0b",
             tag, v.addr, v.wstrb, v.waits, pa, cyc, err);
  endtask

  vec_t vecs[6];

  initial begin
    int   n_setup;
    int   n_ready;
    int   setup2_cyc;
    logic [31:0] paddr2;
    logic pwrite1;
    logic pwrite2;
    logic [31:0] rdata2;
    vec_t rv;

    //          addr          wdata         wstrb waits slv prdata      clr  exp_paddr     pw  pstrb exp_rdata    cyc err eaddr
    vecs[0] = '{32'h1000_0006, 32'h0,        4'h0, 0,  1'b0, 32'h1234_5678, 1'b0, 32'h1000_0004, 1'b0, 4'h0, 32'h1234_5678, 3, 1'b0, 32'h0};
    vecs[1] = '{32'h3000_0008, 32'hA5A5_0000, 4'hC, 3,  1'b0, 32'hFFFF_FFFF, 1'b0, 32'h3000_0008, 1'b1, 4'hC, 32'h0,         6, 1'b0, 32'h0};
    vecs[2] = '{32'h2000_0010, 32'h0,        4'h0, 0,  1'b1, 32'h1111_1111, 1'b0, 32'h2000_0010, 1'b0, 4'h0, 32'hDEAD_BEEF, 3, 1'b1, 32'h2000_0010};
    vecs[3] = '{32'h4000_0003, 32'h0000_00AB, 4'h1, 1,  1'b1, 32'h2222_2222, 1'b0, 32'h4000_0000, 1'b1, 4'h1, 32'h0,         4, 1'b1, 32'h4000_0003};
    vecs[4] = '{32'h5000_0001, 32'h0,        4'h0, 99, 1'b0, 32'h3333_3333, 1'b0, 32'h5000_0000, 1'b0, 4'h0, 32'hDEAD_BEEF, 7, 1'b1, 32'h5000_0001};
    vecs[5] = '{32'h5000_0102, 32'h0,        4'h0, 99, 1'b0, 32'h3333_3333, 1'b1, 32'h5000_0100, 1'b0, 4'h0, 32'hDEAD_BEEF, 7, 1'b1, 32'h5000_0102};

    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_wstrb = 4'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.psel", {31'h0, psel | penable | pwrite}, 32'h0);
    chk("reset.paddr", paddr, 32'h0);
    chk("reset.ready", {31'h0, mem_ready | err}, 32'h0);
    chk("reset.rdata", mem_rdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: write then read, valid renewed on the ready edge.
    @(negedge clk);
    n_setup = 0; n_ready = 0; setup2_cyc = -1; paddr2 = 32'h0;
    pwrite1 = 1'b0; pwrite2 = 1'b1; rdata2 = 32'h0;
    mem_valid = 1'b1; mem_addr = 32'h6000_0000; mem_wdata = 32'h0BAD_F00D; mem_wstrb = 4'hF;
    prdata = 32'hCAFE_0001;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (psel && !penable) begin
        n_setup++;
        if (n_setup == 1) pwrite1 = pwrite;
        if (n_setup == 2) begin setup2_cyc = c; paddr2 = paddr; pwrite2 = pwrite; end
      end
      pready = psel && penable;
      if (mem_ready) begin
        n_ready++;
        if (n_ready == 1) begin mem_addr = 32'h6000_0004; mem_wstrb = 4'h0; end
        if (n_ready == 2) begin rdata2 = mem_rdata; mem_valid = 1'b0; end
      end
    end
    pready = 1'b0;
    chk("b2b.n_setup", 32'(n_setup), 32'd2);
    chk("b2b.n_ready", 32'(n_ready), 32'd2);
    chk("b2b.setup2_cyc", 32'(setup2_cyc), 32'd5);
    chk("b2b.paddr2", paddr2, 32'h6000_0004);
    chk("b2b.pwrite", {30'h0, pwrite1, pwrite2}, 32'h2);
    chk("b2b.rdata2", rdata2, 32'hCAFE_0001);
    $display("txn b2b setups=%0d readies=%0d setup2_cyc=%0d", n_setup, n_ready, setup2_cyc);

    // Reset asserted while in ACCESS.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h7000_000C; mem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst.in_access", {30'h0, psel, penable}, 32'h3);
    rst_n = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("rst.psel", {31'h0, psel | penable}, 32'h0);
    chk("rst.ready", {31'h0, mem_ready}, 32'h0);
    chk("rst.paddr", paddr, 32'h0);
    chk("rst.err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    rv = '{32'h7000_0008, 32'h0, 4'h0, 0, 1'b0, 32'h7777_8888, 1'b0, 32'h7000_0008,
           1'b0, 4'h0, 32'h7777_8888, 3, 1'b0, 32'h0};
    run_txn("after_rst", rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
